// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner with a double-buffered display value,
// guard gaps between digits, leading-zero blanking and an external shared decoder.
module seg_scan_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  num,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_out,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame_done,
  output logic        pending
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DRIVE,
    ST_GUARD
  } state_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } disp_t;

  localparam logic [19:0] DRIVE_LAST = 20'(DIV - 1);
  localparam logic [19:0] GUARD_LAST = 20'(GUARD - 1);

  state_t      state, state_nx;
  disp_t       shadow, shadow_nx;
  disp_t       active, active_nx;
  logic [1:0]  idx, idx_nx;
  logic [19:0] cnt, cnt_nx;
  logic        pending_nx;
  logic        commit;
  logic [3:0]  num_nx, an_nx;
  logic        dp_n_nx;
  logic        blank, blank_nx;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_nx   = state;
    shadow_nx  = shadow;
    active_nx  = active;
    idx_nx     = idx;
    cnt_nx     = cnt;
    pending_nx = pending;
    commit     = 1'b0;
    frame_done = 1'b0;

    unique case (state)
      ST_OFF: begin
        idx_nx = 2'd0;
        cnt_nx = 20'd0;
        if (enable) begin
          state_nx = ST_DRIVE;
          commit   = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_nx = ST_OFF;
          idx_nx   = 2'd0;
          cnt_nx   = 20'd0;
        end else if (cnt == DRIVE_LAST) begin
          state_nx = ST_GUARD;
          cnt_nx   = 20'd0;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      ST_GUARD: begin
        if (!enable) begin
          state_nx = ST_OFF;
          idx_nx   = 2'd0;
          cnt_nx   = 20'd0;
        end else if (cnt == GUARD_LAST) begin
          state_nx = ST_DRIVE;
          cnt_nx   = 20'd0;
          idx_nx   = idx + 2'd1;
          if (idx == 2'd3) begin
            frame_done = 1'b1;
            commit     = pending;
          end
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      default: begin
        state_nx = ST_OFF;
        idx_nx   = 2'd0;
        cnt_nx   = 20'd0;
      end
    endcase

    // Commit reads the old shadow; a simultaneous load then overwrites shadow and re-arms pending.
    if (commit) begin
      active_nx  = shadow;
      pending_nx = 1'b0;
    end
    if (load) begin
      shadow_nx  = '{val: value, dp: dp_in};
      pending_nx = 1'b1;
    end

    // Digit outputs are derived from next state so num, an and dp_n move on one edge.
    num_nx  = active_nx.val[{idx_nx, 2'b00} +: 4];
    an_nx   = (state_nx == ST_DRIVE) ? ~(4'b0001 << idx_nx) : 4'hF;
    dp_n_nx = (state_nx == ST_DRIVE) ? ~active_nx.dp[idx_nx] : 1'b1;

    unique case (idx_nx)
      2'd0: blank_nx = 1'b0;
      2'd1: blank_nx = blank_lz && (active_nx.val[15:4] == 12'h000);
      2'd2: blank_nx = blank_lz && (active_nx.val[15:8] == 8'h00);
      2'd3: blank_nx = blank_lz && (active_nx.val[15:12] == 4'h0);
      default: blank_nx = 1'b0;
    endcase
  end

  // NOTE: the display buffers are only 40 flops, so they are reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      shadow  <= '0;
      active  <= '0;
      idx     <= 2'd0;
      cnt     <= 20'd0;
      pending <= 1'b0;
      num     <= 4'd0;
      an      <= 4'hF;
      dp_n    <= 1'b1;
      blank   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_nx;
      shadow  <= shadow_nx;
      active  <= active_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
      num     <= num_nx;
      an      <= an_nx;
      dp_n    <= dp_n_nx;
      blank   <= blank_nx;
    end
  end

  assign seg_out = (state == ST_DRIVE && !blank) ? seg_in : 7'h7F;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000: drive cycles per digit, legal range 2..2^20.
REQ-002 Parameter GUARD, default 16: all-anodes-off cycles between digits, legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  1 = scan display; 0 = display dark.
REQ-006 load  input  1  one-cycle strobe; captures value and dp_in.
REQ-007 value  input  16  four hex nibbles; digit 0 = [3:0], digit 3 = [15:12].
REQ-008 dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-009 blank_lz  input  1  1 = suppress leading zero digits.
REQ-010 num  output  4  nibble for the shared external hex-to-7-segment decoder, registered.
REQ-011 seg_in  input  7  active-low segment pattern returned by that decoder for num, combinational.
REQ-012 seg_out  output  7  active-low segments to the panel.
REQ-013 an  output  4  active-low digit anodes, registered.
REQ-014 dp_n  output  1  active-low decimal point, registered.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.
REQ-016 pending  output  1  1 = captured value not yet shown.

Function
REQ-017 The block SHALL hold the registers shadow (16+4 bits), active (16+4 bits), idx (2 bits), cnt (20 bits), pending, and a state register with states OFF, DRIVE and GUARD.
REQ-018 load=1 SHALL write value and dp_in into shadow and set pending on the next edge, in any state.
REQ-019 OFF: an=4'b1111, dp_n=1, seg_out=7'h7F, idx=0, cnt=0; when enable=1, the block SHALL move to DRIVE, copy shadow to active, and clear pending (commit).
REQ-020 DRIVE: an has exactly bit idx low, num=active nibble idx, and dp_n=~active dp[idx]; cnt counts 0..DIV-1; at DIV-1 the block SHALL move to GUARD with cnt=0.
REQ-021 GUARD: an=4'b1111, dp_n=1, seg_out=7'h7F; cnt counts 0..GUARD-1; at GUARD-1 the block SHALL move to DRIVE with idx=idx+1 modulo 4, cnt=0.
REQ-022 Leaving GUARD with idx=3 (wrap to 0) SHALL pulse frame_done for exactly that cycle and commit shadow to active if pending=1.
REQ-023 Load on the commit cycle: active takes the old shadow, shadow takes the new value, and pending SHALL remain 1.
REQ-024 Leading-zero blank: digit i>0 is blank when blank_lz=1 and active nibbles i..3 are all 0; digit 0 is never blanked; dp is unaffected by blanking.
REQ-025 seg_out SHALL equal seg_in in DRIVE for a non-blank digit, and 7'h7F otherwise; it is combinational from registered state and seg_in only.
REQ-026 num, an and dp_n SHALL change on the same edge, so that seg_in is settled in the same cycle as an.
REQ-027 enable=0 in DRIVE or GUARD SHALL force OFF on the next edge, with no frame_done and no commit; shadow and pending are kept.
REQ-028 Scan period SHALL be exactly 4*(DIV+GUARD) cycles per frame, with no drift.

Reset
REQ-029 rst_n=0 SHALL immediately force state=OFF, an=4'b1111, dp_n=1, seg_out=7'h7F, num=0, frame_done=0, pending=0, shadow=0, active=0, idx=0, cnt=0.
REQ-030 After rst_n rises with enable=1, the first DRIVE cycle SHALL occur on the second rising edge, showing digit 0 of shadow.
REQ-031 Reset asserted mid-frame SHALL discard any pending value.

Verification (DIV=4, GUARD=2, ideal decoder model)
REQ-032 Reset release, enable=1, load value=16'h1234 dp_in=0 -> an sequence 1110(4 cycles), 1111(2), 1101(4), 1111(2), 1011, 0111; num sequence 4,3,2,1; frame_done pulses every 24 cycles.
REQ-033 value=16'h0005, blank_lz=1 -> digits 3..1 seg_out=7'h7F while their anode is low; digit 0 is driven from num=5; with blank_lz=0, digits 3..1 are driven from num=0.
REQ-034 Load 16'hABCD mid-frame -> pending=1 until the frame_done cycle; the next DRIVE on digit 0 shows num=D; the partly scanned frame still shows the old value.
REQ-035 Load on the exact frame_done cycle -> old shadow is shown, pending stays 1, and the new value appears one frame later.
REQ-036 enable dropped during DRIVE on digit 2 -> next cycle an=1111, seg_out=7F, no frame_done; on re-enable, the scan restarts at digit 0.
REQ-037 rst_n pulsed low mid-DRIVE, asynchronous to clk -> outputs go dark before the next edge; pending=0 and active=0.
